ffq_arbiter: RTL and testbench
==============================

# ffq_arbiter

Lockout arbiter for the fastest-finger-first buzzer: it synchronizes and debounces the four raw player buttons, arms on a host command, and latches exactly one winner on the first qualifying press. It also flags players who were already holding a button when the round was armed, and ends unanswered rounds after a timeout. Its one-hot `winner` output drives the existing player-to-7-segment decoder directly, so `4'b0000` (no winner) displays "0".

## Interface
Parameters:
- `N_PLAYERS`, 4: number of buttons. Fixed at 4 for this release; the width is carried for the package.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synced cycles needed before a debounced level changes. Must be ≥1.
- `TIMEOUT_CYCLES`, 50_000_000: cycles in ARMED with no accepted press before timeout. 0 disables the timeout.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `arm` in 1: host start-round pulse or level. It is sampled only in IDLE.
- `clear` in 1: host clear. It returns the block to IDLE from any state.
- `player` in 4: raw, asynchronous, active-high buttons.
- `winner` out 4: one-hot winner, or 0000 when there is none. Registered.
- `armed` out 1: high in ARMED.
- `locked` out 1: high in LOCKED.
- `timeout` out 1: high in TIMEOUT.
- `foul` out 4: sticky; bit i is set if player i was held at arm.

## Operation
- Input path, per bit:
  - 2-flop synchronizer, then a debouncer.
  - The debounced level takes the synced value once that value has differed from the current debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle where synced equals debounced resets the count.
  - A press is a rising edge of the debounced level, 1-cycle pulse.
- State machine: IDLE, ARMED, LOCKED, TIMEOUT.
  - IDLE → ARMED on `arm`. This loads the timeout counter to 0.
  - ARMED → LOCKED on any accepted press. `winner` latches the lowest-index accepted press, so a same-cycle tie resolves player0 > player1 > player2 > player3.
  - ARMED → TIMEOUT when the counter reaches `TIMEOUT_CYCLES - 1` with no accepted press that cycle. A press in that same cycle wins; LOCKED takes priority.
  - LOCKED and TIMEOUT hold until `clear`.
  - Any state → IDLE on `clear`. This zeroes `winner` and `foul`.
- `clear` has priority over `arm` and over presses in the same cycle.
- `arm` outside IDLE is ignored.
- Fouls:
  - On the IDLE→ARMED transition, every player whose debounced level is high gets `foul[i]=1` and `mask[i]=1`.
  - A masked player cannot win.
  - `mask[i]` clears when that player's debounced level falls. A later rising edge is then accepted.
  - `foul` stays set until `clear`.
- Presses in IDLE, LOCKED and TIMEOUT are discarded. They are not queued.
- Timeout counter: width `$clog2(TIMEOUT_CYCLES+1)`, saturating, increments only in ARMED.

## Timing
- Reset values: state IDLE, `winner`=0000, `foul`=0000, `armed`=`locked`=`timeout`=0. Sync, debounce and mask registers are all 0.
- Status outputs (`armed`, `locked`, `timeout`) are decoded from the registered state, with no combinational path from inputs.
- `arm` at edge k gives `armed`=1 after edge k.
- Press latency: raw `player[i]` rises before edge t and stays stable. `winner` is visible after edge t + `DEBOUNCE_CYCLES` + 3:
  - 2 synchronizer stages,
  - `DEBOUNCE_CYCLES` count,
  - 1 debounced-level register,
  - 1 winner/state register.
- `locked` rises in the same cycle as `winner`.
- `clear` at edge k gives IDLE, `winner`=0 and `foul`=0 after edge k.
- Releasing a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced level.
- `rst_n` mid-round asynchronously forces all reset values. The first accepted round after reset requires a fresh `arm`.

## Structure
- Package `ffq_pkg` holds:
  - `N_PLAYERS`,
  - state enum `ffq_state_t` {IDLE, ARMED, LOCKED, TIMEOUT},
  - `NO_WINNER = 4'b0000`,
  - a priority-pick function (lowest set bit → one-hot).
- Sub-module `ffq_debounce`: one instance per player. It contains the synchronizer and debounce counter, with outputs `level` and `rise`.
- Top `ffq_arbiter` holds the FSM, mask/foul registers, timeout counter and winner register.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=20.
- Single press: reset, arm, then hold player2 from cycle 10 → `winner`=0100 and `locked`=1 exactly 7 cycles after the first sampled high. Later presses by players 0, 1 and 3 leave `winner` at 0100.
- Tie: arm, then raise player3 and player1 in the same cycle → `winner`=0010.
- Bounce: arm, then toggle player0 with 3-cycle pulses for 20 cycles → no win. Then hold player0 stable → `winner`=0001 after 7 cycles.
- Foul: hold player1, then arm → `foul`=0010 and player1 cannot win while held. Release player1 ≥4 cycles, re-press → `winner`=0010 and `foul` stays 0010.
- Timeout and clear: arm with no press → `timeout`=1, `winner`=0000 after 20 cycles. Assert `clear` and `arm` in the same cycle → IDLE, all outputs 0.
- Async reset: assert `rst_n`=0 while LOCKED, mid-cycle → all outputs 0 immediately. A press without `arm` after release → `winner` remains 0000.

Source files
------------

// File: rtl/ffq_pkg.sv
// ffq_pkg: shared definitions for the fastest-finger-first arbiter.
//   N_PLAYERS   - number of player buttons
//   ffq_state_t - arbiter round state
//   NO_WINNER   - winner code shown as "0" on the display
//   prio_pick   - lowest set request bit returned as a one-hot grant
package ffq_pkg;

    localparam int N_PLAYERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } ffq_state_t;

    localparam logic [N_PLAYERS-1:0] NO_WINNER = 4'b0000;

    // Walk from the top bit down so the lowest-index request is the last
    // one written and therefore wins.
    function automatic logic [N_PLAYERS-1:0] prio_pick(input logic [N_PLAYERS-1:0] req);
        logic [N_PLAYERS-1:0] gnt;
        gnt = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ffq_debounce.sv
// ffq_debounce: 2-flop synchronizer plus debouncer for one raw button.
//   clk   in  - system clock
//   rst_n in  - asynchronous active-low reset
//   din   in  - raw asynchronous button level
//   level out - debounced level
//   rise  out - 1-cycle pulse on each rising edge of level (registered)
// The count register reaches DEBOUNCE_CYCLES after that many consecutive
// disagreeing synced cycles; level takes the synced value on the next edge.
module ffq_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_DONE) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/ffq_arbiter.sv
// ffq_arbiter: lockout arbiter for the fastest-finger-first buzzer.
//   clk     in  - system clock
//   rst_n   in  - asynchronous active-low reset
//   arm     in  - start a round (only looked at in IDLE)
//   clear   in  - return to IDLE from any state, zero winner and foul
//   player  in  - raw asynchronous active-high buttons
//   winner  out - registered one-hot winner, 0000 when none
//   armed   out - state is ARMED
//   locked  out - state is LOCKED
//   timeout out - state is TIMEOUT
//   foul    out - sticky; player was holding the button when armed
//
// state   | meaning
// IDLE    | waiting for arm, presses discarded
// ARMED   | round open, first unmasked press wins, timer running
// LOCKED  | winner latched, held until clear
// TIMEOUT | no press within TIMEOUT_CYCLES, held until clear
module ffq_arbiter #(
    parameter int N_PLAYERS       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 clear,
    input  logic [N_PLAYERS-1:0] player,
    output logic [N_PLAYERS-1:0] winner,
    output logic                 armed,
    output logic                 locked,
    output logic                 timeout,
    output logic [N_PLAYERS-1:0] foul
);

    import ffq_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [N_PLAYERS-1:0] level;
    logic [N_PLAYERS-1:0] rise;
    logic [N_PLAYERS-1:0] accept;

    ffq_state_t           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_PLAYERS-1:0] winner_q, winner_d;
    logic [N_PLAYERS-1:0] foul_q, foul_d;
    logic [N_PLAYERS-1:0] mask_q, mask_d;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_deb
        ffq_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (player[g]),
            .level(level[g]),
            .rise (rise[g])
        );
    end

    assign accept = rise & ~mask_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        winner_d = winner_q;
        foul_d   = foul_q;
        // A mask bit only survives while that player keeps holding.
        mask_d   = mask_q & level;

        if (clear) begin
            state_d  = IDLE;
            timer_d  = '0;
            winner_d = NO_WINNER;
            foul_d   = '0;
            mask_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = ARMED;
                        timer_d = '0;
                        foul_d  = foul_q | level;
                        mask_d  = level;
                    end
                end
                ARMED: begin
                    if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
                    // A press landing on the final timer cycle still wins.
                    if (|accept) begin
                        state_d  = LOCKED;
                        winner_d = prio_pick(accept);
                    end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                        state_d = TIMEOUT;
                    end
                end
                LOCKED:  state_d = LOCKED;
                TIMEOUT: state_d = TIMEOUT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            winner_q <= NO_WINNER;
            foul_q   <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            winner_q <= winner_d;
            foul_q   <= foul_d;
            mask_q   <= mask_d;
        end
    end

    assign winner  = winner_q;
    assign foul    = foul_q;
    assign armed   = (state_q == ARMED);
    assign locked  = (state_q == LOCKED);
    assign timeout = (state_q == TIMEOUT);

endmodule

// File: tb/tb_ffq_arbiter.sv
// tb_ffq_arbiter: directed bench for ffq_arbiter with DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=20. Observed vector is {winner, armed, locked, timeout, foul}.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_ffq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm;
    logic       clear;
    logic [3:0] player;
    logic [3:0] winner;
    logic       armed;
    logic       locked;
    logic       timeout;
    logic [3:0] foul;
    logic [10:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ffq_arbiter #(
        .N_PLAYERS      (4),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arm    (arm),
        .clear  (clear),
        .player (player),
        .winner (winner),
        .armed  (armed),
        .locked (locked),
        .timeout(timeout),
        .foul   (foul)
    );

    assign obs = {winner, armed, locked, timeout, foul};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; player = 4'b0000;
        #3;
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs, 11'b0000_000_0000);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", obs, 11'b0000_000_0000);
        end
    endtask

    task automatic test_single_press();
        pulse_arm();
        n_tests++;
        if (obs !== 11'b0000_100_0000) begin
            n_fail++;
            $display("FAIL single_armed: got %b want %b", obs, 11'b0000_100_0000);
        end
        tick(8);
        player = 4'b0100;
        tick(7);
        n_tests++;
        if (obs !== 11'b0000_100_0000) begin
            n_fail++;
            $display("FAIL single_t6: got %b want %b", obs, 11'b0000_100_0000);
        end
        tick(1);
        n_tests++;
        if (obs !== 11'b0100_010_0000) begin
            n_fail++;
            $display("FAIL single_t7: got %b want %b", obs, 11'b0100_010_0000);
        end
        // Other players pile in and arm is held while locked: nothing moves.
        player = 4'b1111;
        arm = 1'b1;
        tick(10);
        arm = 1'b0;
        n_tests++;
        if (obs !== 11'b0100_010_0000) begin
            n_fail++;
            $display("FAIL single_later: got %b want %b", obs, 11'b0100_010_0000);
        end
        player = 4'b0000;
        tick(8);
        pulse_clear();
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL single_clear: got %b want %b", obs, 11'b0000_000_0000);
        end
    endtask

    task automatic test_tie();
        pulse_arm();
        player = 4'b1010;
        tick(8);
        n_tests++;
        if (obs !== 11'b0010_010_0000) begin
            n_fail++;
            $display("FAIL tie: got %b want %b", obs, 11'b0010_010_0000);
        end
        player = 4'b0000;
        tick(8);
        pulse_clear();
    endtask

    task automatic test_bounce();
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            player = ((i % 6) < 3) ? 4'b0001 : 4'b0000;
            tick(1);
        end
        player = 4'b0000;
        tick(8);
        // Round expired with no accepted press.
        n_tests++;
        if (obs !== 11'b0000_001_0000) begin
            n_fail++;
            $display("FAIL bounce_nowin: got %b want %b", obs, 11'b0000_001_0000);
        end
        pulse_clear();
        pulse_arm();
        player = 4'b0001;
        tick(7);
        n_tests++;
        if (obs !== 11'b0000_100_0000) begin
            n_fail++;
            $display("FAIL bounce_t6: got %b want %b", obs, 11'b0000_100_0000);
        end
        tick(1);
        n_tests++;
        if (obs !== 11'b0001_010_0000) begin
            n_fail++;
            $display("FAIL bounce_stable: got %b want %b", obs, 11'b0001_010_0000);
        end
        player = 4'b0000;
        tick(8);
        pulse_clear();
    endtask

    task automatic test_foul();
        player = 4'b0010;
        tick(8);
        pulse_arm();
        n_tests++;
        if (obs !== 11'b0000_100_0010) begin
            n_fail++;
            $display("FAIL foul_arm: got %b want %b", obs, 11'b0000_100_0010);
        end
        tick(4);
        player = 4'b0000;
        tick(7);
        player = 4'b0010;
        tick(7);
        n_tests++;
        if (obs !== 11'b0000_100_0010) begin
            n_fail++;
            $display("FAIL foul_prewin: got %b want %b", obs, 11'b0000_100_0010);
        end
        tick(1);
        n_tests++;
        if (obs !== 11'b0010_010_0010) begin
            n_fail++;
            $display("FAIL foul_repress: got %b want %b", obs, 11'b0010_010_0010);
        end
        player = 4'b0000;
        tick(8);
        pulse_clear();
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL foul_clear: got %b want %b", obs, 11'b0000_000_0000);
        end
    endtask

    task automatic test_timeout_clear();
        pulse_arm();
        tick(19);
        n_tests++;
        if (obs !== 11'b0000_100_0000) begin
            n_fail++;
            $display("FAIL timeout_t19: got %b want %b", obs, 11'b0000_100_0000);
        end
        tick(1);
        n_tests++;
        if (obs !== 11'b0000_001_0000) begin
            n_fail++;
            $display("FAIL timeout_t20: got %b want %b", obs, 11'b0000_001_0000);
        end
        clear = 1'b1;
        arm   = 1'b1;
        tick(1);
        clear = 1'b0;
        arm   = 1'b0;
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL clear_over_arm: got %b want %b", obs, 11'b0000_000_0000);
        end
        tick(2);
    endtask

    task automatic test_press_at_timeout();
        pulse_arm();
        tick(12);
        player = 4'b1000;
        tick(7);
        n_tests++;
        if (obs !== 11'b0000_100_0000) begin
            n_fail++;
            $display("FAIL edge_t19: got %b want %b", obs, 11'b0000_100_0000);
        end
        tick(1);
        n_tests++;
        if (obs !== 11'b1000_010_0000) begin
            n_fail++;
            $display("FAIL edge_press_wins: got %b want %b", obs, 11'b1000_010_0000);
        end
        player = 4'b0000;
        tick(8);
        pulse_clear();
    endtask

    task automatic test_async_reset();
        pulse_arm();
        player = 4'b0010;
        tick(8);
        n_tests++;
        if (obs !== 11'b0010_010_0000) begin
            n_fail++;
            $display("FAIL async_locked: got %b want %b", obs, 11'b0010_010_0000);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL async_rst_now: got %b want %b", obs, 11'b0000_000_0000);
        end
        tick(2);
        rst_n = 1'b1;
        tick(12);
        n_tests++;
        if (obs !== 11'b0000_000_0000) begin
            n_fail++;
            $display("FAIL async_no_arm: got %b want %b", obs, 11'b0000_000_0000);
        end
        player = 4'b0000;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_tie();
        test_bounce();
        test_foul();
        test_timeout_clear();
        test_press_at_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
